// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: host write handshake and frame buffer RAM port
interface matrix_scan_ctrl_if;
    logic       host_wr_req;
    logic [3:0] host_wr_row;
    logic [4:0] host_wr_col;
    logic [1:0] host_wr_data;
    logic       host_wr_ack;
    logic [8:0] fb_addr;
    logic       fb_we;
    logic [1:0] fb_wdata;
    logic [1:0] fb_rdata;

    modport master (
        output host_wr_req, host_wr_row, host_wr_col, host_wr_data, fb_rdata,
        input  host_wr_ack, fb_addr, fb_we, fb_wdata
    );

    modport slave (
        input  host_wr_req, host_wr_row, host_wr_col, host_wr_data, fb_rdata,
        output host_wr_ack, fb_addr, fb_we, fb_wdata
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: LED matrix row/pixel scan scheduler sharing the frame buffer port with a host writer
module matrix_scan_ctrl #(
    parameter int COLS         = 32,
    parameter int ROWS         = 16,
    parameter int PHASE_CYCLES = 16,
    parameter int ROW_HOLD     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    matrix_scan_ctrl_if.slave bus,
    output logic              red,
    output logic              green,
    output logic              step,
    output logic              latch,
    output logic              blank,
    output logic [3:0]        addr,
    output logic              frame_start
);
    localparam int PW = $clog2(2 * PHASE_CYCLES);
    localparam int HW = $clog2(ROW_HOLD + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * PHASE_CYCLES - 1);
    localparam logic [PW-1:0] LAT_LAST = PW'(PHASE_CYCLES - 1);
    localparam logic [PW-1:0] PH_HIGH  = PW'(PHASE_CYCLES);
    localparam logic [PW-1:0] PH_DATA  = PW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);
    localparam logic [4:0]    COL_LAST = 5'(COLS - 1);
    localparam logic [3:0]    ROW_LAST = 4'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic [HW-1:0] hold, hold_n;
    logic [3:0]    row, row_n;
    logic [4:0]    col, col_n;
    logic          fetch_n, grant_n;

    // next-state schedule; port owner for the next cycle is decided here
    always_comb begin
        state_n = state;
        ph_n    = ph;
        hold_n  = hold;
        row_n   = row;
        col_n   = col;
        case (state)
            IDLE: if (enable) begin
                state_n = SHIFT;
                ph_n    = '0;
                row_n   = '0;
                col_n   = '0;
            end
            SHIFT: begin
                ph_n = ph == PH_LAST ? '0 : ph + PW'(1);
                if (ph == PH_LAST) begin
                    col_n   = col == COL_LAST ? 5'd0 : col + 5'd1;
                    state_n = col == COL_LAST ? LATCH : SHIFT;
                end
            end
            LATCH: begin
                ph_n = ph + PW'(1);
                if (ph == LAT_LAST) begin
                    state_n = DISPLAY;
                    ph_n    = '0;
                    hold_n  = '0;
                end
            end
            DISPLAY: begin
                hold_n = hold + HW'(1);
                if (hold == HOLD_LAST) begin
                    state_n = enable ? SHIFT : IDLE;
                    row_n   = row == ROW_LAST ? 4'd0 : row + 4'd1;
                    col_n   = '0;
                    ph_n    = '0;
                    hold_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        fetch_n = state_n == SHIFT && ph_n == '0;
        grant_n = bus.host_wr_req && !fetch_n && !bus.host_wr_ack;
    end

    // state and registered outputs, all derived from the next-cycle schedule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ph              <= '0;
            hold            <= '0;
            row             <= '0;
            col             <= '0;
            red             <= 1'b0;
            green           <= 1'b0;
            step            <= 1'b0;
            latch           <= 1'b0;
            blank           <= 1'b1;
            addr            <= '0;
            frame_start     <= 1'b0;
            bus.fb_addr     <= '0;
            bus.fb_we       <= 1'b0;
            bus.fb_wdata    <= '0;
            bus.host_wr_ack <= 1'b0;
        end else begin
            state           <= state_n;
            ph              <= ph_n;
            hold            <= hold_n;
            row             <= row_n;
            col             <= col_n;
            step            <= state_n == SHIFT && ph_n >= PH_HIGH;
            latch           <= state_n == LATCH;
            blank           <= state_n != DISPLAY;
            frame_start     <= fetch_n && row_n == '0 && col_n == '0;
            bus.fb_we       <= grant_n;
            bus.host_wr_ack <= grant_n;
            if (state_n == LATCH && state != LATCH)
                addr <= row_n;
            if (state == SHIFT && ph == PH_DATA)
                {green, red} <= bus.fb_rdata;
            if (fetch_n)
                bus.fb_addr <= {row_n, col_n};
            else if (grant_n) begin
                bus.fb_addr  <= {bus.host_wr_row, bus.host_wr_col};
                bus.fb_wdata <= bus.host_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed checks of scan timing, data path, arbitration and reset
module tb_matrix_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       red, green, step, latch, blank, frame_start;
    logic [3:0] addr;
    logic [1:0] mem [512];
    int         errors = 0;
    int         checks = 0;

    matrix_scan_ctrl_if bus();

    matrix_scan_ctrl #(.COLS(4), .ROWS(2), .PHASE_CYCLES(2), .ROW_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.slave),
        .red(red), .green(green), .step(step), .latch(latch), .blank(blank),
        .addr(addr), .frame_start(frame_start)
    );

    // system clock
    always #5 clk = ~clk;

    // single-port frame buffer RAM, registered read
    always @(posedge clk) begin
        if (bus.fb_we) mem[bus.fb_addr] <= bus.fb_wdata;
        bus.fb_rdata <= mem[bus.fb_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [22:0] got;
        bus.host_wr_req = 1'b0; bus.host_wr_row = '0; bus.host_wr_col = '0; bus.host_wr_data = '0;
        tick(); tick();
        got = {red, green, step, latch, blank, addr, frame_start, bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.host_wr_ack};
        checks++; if (got !== {4'b0000, 1'b1, 18'd0}) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, {4'b0000, 1'b1, 18'd0}); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL idle_blank: got %b want 1", blank); end
        checks++; if (step !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL idle_quiet: step=%b frame_start=%b want 0,0", step, frame_start); end
    endtask

    task automatic test_host_idle;
        logic [1:0] d [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
        int lat;
        for (int k = 0; k < 8; k++) begin
            bus.host_wr_req = 1'b1; bus.host_wr_row = 4'(k / 4); bus.host_wr_col = 5'(k % 4); bus.host_wr_data = d[k];
            lat = -1;
            for (int i = 1; i <= 6; i++) begin
                tick();
                if (bus.host_wr_ack) begin lat = i; break; end
            end
            checks++; if (lat != 1) begin errors++; $display("FAIL idle_ack_latency[%0d]: got %0d want 1", k, lat); end
            checks++; if ({bus.fb_we, bus.fb_addr, bus.fb_wdata} !== {1'b1, 4'(k / 4), 5'(k % 4), d[k]}) begin
                errors++; $display("FAIL idle_write_bus[%0d]: we=%b addr=%0d data=%b want 1,%0d,%b", k, bus.fb_we, bus.fb_addr, bus.fb_wdata, (k / 4) * 32 + k % 4, d[k]);
            end
            bus.host_wr_req = 1'b0;
            tick();
        end
        checks++; if (mem[0] !== 2'b01) begin errors++; $display("FAIL idle_mem_r0c0: got %b want 01", mem[0]); end
        checks++; if (mem[35] !== 2'b01) begin errors++; $display("FAIL idle_mem_r1c3: got %b want 01", mem[35]); end
    endtask

    task automatic test_frame;
        bit s_step [110], s_latch [110], s_blank [110], s_fs [110];
        logic [1:0] s_rg [110];
        logic [3:0] s_addr [110];
        logic [1:0] exp_rg [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10};
        int fs0, fs1, rises, lat_n, lit_n;
        enable = 1'b1;
        for (int i = 0; i < 110; i++) begin
            tick();
            s_step[i] = step; s_latch[i] = latch; s_blank[i] = blank; s_fs[i] = frame_start;
            s_rg[i] = {red, green}; s_addr[i] = addr;
        end
        fs0 = -1; fs1 = -1;
        for (int i = 0; i < 110; i++)
            if (s_fs[i]) begin
                if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i;
            end
        checks++; if (fs0 != 0) begin errors++; $display("FAIL frame_start_first: got %0d want 0", fs0); end
        checks++; if (fs1 - fs0 != 52) begin errors++; $display("FAIL frame_period: got %0d want 52", fs1 - fs0); end
        rises = 0; lat_n = 0; lit_n = 0;
        for (int i = 0; i < 26; i++) begin
            if (s_step[i] && (i == 0 || !s_step[i-1])) rises++;
            if (s_latch[i]) lat_n++;
            if (!s_blank[i]) lit_n++;
        end
        checks++; if (rises != 4) begin errors++; $display("FAIL row_step_rises: got %0d want 4", rises); end
        checks++; if (lat_n != 2) begin errors++; $display("FAIL row_latch_cycles: got %0d want 2", lat_n); end
        checks++; if (lit_n != 8) begin errors++; $display("FAIL row_lit_cycles: got %0d want 8", lit_n); end
        checks++; if ({s_blank[17], s_blank[18], s_blank[25], s_blank[26]} !== 4'b1001) begin
            errors++; $display("FAIL blank_edges: got %b want 1001", {s_blank[17], s_blank[18], s_blank[25], s_blank[26]});
        end
        checks++; if ({s_latch[16], s_addr[16], s_latch[42], s_addr[42], s_latch[68], s_addr[68]} !== {1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 4'd0}) begin
            errors++; $display("FAIL addr_sequence: got %0d,%0d,%0d want 0,1,0", s_addr[16], s_addr[42], s_addr[68]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (!s_step[(k / 4) * 26 + (k % 4) * 4 + 2] || s_rg[(k / 4) * 26 + (k % 4) * 4 + 2] !== exp_rg[k]) begin
                errors++; $display("FAIL pixel_data[%0d]: step=%b red_green=%b want 1,%b", k, s_step[(k / 4) * 26 + (k % 4) * 4 + 2], s_rg[(k / 4) * 26 + (k % 4) * 4 + 2], exp_rg[k]);
            end
        end
    endtask

    task automatic test_collision;
        bit ok;
        int ack_i, we_cnt;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL collision_sync: got no frame_start want one within 300 cycles"); end
        tick(); tick(); tick();
        bus.host_wr_req = 1'b1; bus.host_wr_row = 4'd0; bus.host_wr_col = 5'd1; bus.host_wr_data = 2'b00;
        ack_i = -1; we_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus.fb_we) we_cnt++;
            if (i == 1) begin
                checks++; if (bus.fb_we !== 1'b0 || bus.fb_addr !== 9'd1) begin errors++; $display("FAIL collision_fetch: we=%b addr=%0d want 0,1", bus.fb_we, bus.fb_addr); end
            end
            if (i == 3) begin
                checks++; if (step !== 1'b1 || {red, green} !== 2'b01) begin errors++; $display("FAIL collision_old_data: step=%b red_green=%b want 1,01", step, {red, green}); end
            end
            if (bus.host_wr_ack && ack_i < 0) begin ack_i = i; bus.host_wr_req = 1'b0; end
        end
        checks++; if (ack_i != 2) begin errors++; $display("FAIL collision_ack_latency: got %0d want 2", ack_i); end
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL collision_we_pulses: got %0d want 1", we_cnt); end
        checks++; if (mem[1] !== 2'b00) begin errors++; $display("FAIL collision_mem: got %b want 00", mem[1]); end
        sync_frame(ok);
        tick(); tick(); tick(); tick(); tick(); tick();
        checks++; if (step !== 1'b1 || {red, green} !== 2'b00) begin errors++; $display("FAIL collision_new_data: step=%b red_green=%b want 1,00", step, {red, green}); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int a1, a2, we_cnt;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_sync: got no frame_start want one within 300 cycles"); end
        bus.host_wr_req = 1'b1; bus.host_wr_row = 4'd0; bus.host_wr_col = 5'd2; bus.host_wr_data = 2'b01;
        a1 = -1; a2 = -1; we_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.fb_we) we_cnt++;
            if (bus.host_wr_ack) begin
                if (a1 < 0) begin
                    a1 = i; bus.host_wr_col = 5'd3; bus.host_wr_data = 2'b10;
                end else if (a2 < 0) begin
                    a2 = i; bus.host_wr_req = 1'b0;
                end
            end
        end
        checks++; if (a1 != 1) begin errors++; $display("FAIL b2b_first_ack: got %0d want 1", a1); end
        checks++; if (a2 != 3) begin errors++; $display("FAIL b2b_second_ack: got %0d want 3", a2); end
        checks++; if (we_cnt != 2) begin errors++; $display("FAIL b2b_we_pulses: got %0d want 2", we_cnt); end
        checks++; if ({mem[2], mem[3]} !== 4'b0110) begin errors++; $display("FAIL b2b_mem: got %b want 0110", {mem[2], mem[3]}); end
    endtask

    task automatic test_disable;
        bit ok, prev;
        int rises, lat_n, lit_n, fs_n;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL disable_sync: got no frame_start want one within 300 cycles"); end
        for (int i = 0; i < 30; i++) tick();
        enable = 1'b0;
        prev = step; rises = 0; lat_n = 0; lit_n = 0; fs_n = 0;
        for (int i = 31; i <= 70; i++) begin
            tick();
            if (step && !prev) rises++;
            prev = step;
            if (latch) lat_n++;
            if (!blank) lit_n++;
            if (frame_start) fs_n++;
        end
        checks++; if (rises != 3) begin errors++; $display("FAIL disable_step_rises: got %0d want 3", rises); end
        checks++; if (lat_n != 2) begin errors++; $display("FAIL disable_latch_cycles: got %0d want 2", lat_n); end
        checks++; if (lit_n != 8) begin errors++; $display("FAIL disable_lit_cycles: got %0d want 8", lit_n); end
        checks++; if (fs_n != 0) begin errors++; $display("FAIL disable_frame_start: got %0d want 0", fs_n); end
        checks++; if ({blank, step, latch, addr} !== {3'b100, 4'd1}) begin errors++; $display("FAIL disable_idle: blank=%b step=%b latch=%b addr=%0d want 1,0,0,1", blank, step, latch, addr); end
    endtask

    task automatic test_async_reset;
        bit ok;
        logic [22:0] got;
        enable = 1'b1;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_sync: got no frame_start want one within 300 cycles"); end
        tick(); tick();
        checks++; if (step !== 1'b1 || red !== 1'b1) begin errors++; $display("FAIL areset_pre: step=%b red=%b want 1,1", step, red); end
        bus.host_wr_req = 1'b1; bus.host_wr_row = 4'd0; bus.host_wr_col = 5'd1; bus.host_wr_data = 2'b11;
        #2 rst_n = 1'b0;
        #1 got = {red, green, step, latch, blank, addr, frame_start, bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.host_wr_ack};
        checks++; if (got !== {4'b0000, 1'b1, 18'd0}) begin errors++; $display("FAIL areset_outputs: got %h want %h", got, {4'b0000, 1'b1, 18'd0}); end
        bus.host_wr_req = 1'b0; enable = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({blank, step, frame_start, bus.fb_we} !== 4'b1000) begin errors++; $display("FAIL areset_idle: blank=%b step=%b fs=%b we=%b want 1,0,0,0", blank, step, frame_start, bus.fb_we); end
        checks++; if (mem[1] !== 2'b00) begin errors++; $display("FAIL areset_no_write: got %b want 00", mem[1]); end
    endtask

    // directed scenario sequence
    initial begin
        test_reset();
        test_host_idle();
        test_frame();
        test_collision();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
